// File: rtl/conv_pkg.sv
// Shared definitions for the convolution/max-pool engine and its downstream stages.
//  - csel codes for the shared memory select bus
//  - streamer FSM state encoding
//  - rounding helper for the global average of a 1024-word map
package conv_pkg;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int SUM_W = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } stream_state_e;

  // Round-to-nearest divide by 1024 (the map has 32*32 words).
  // The largest possible sum plus 512 still fits in SUM_W bits.
  function automatic logic [SUM_W-1:0] round_avg(input logic [SUM_W-1:0] sum);
    return (sum + 30'd512) >> 10;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head.
// Ports:
//  clk, reset      posedge clock, synchronous active-high reset
//  i_push, i_data  write side
//  i_pop           read side; o_data is the current head
//  o_empty         no entries held
//  o_count         number of entries held (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == CNT_W'(0));
  // A pop on a full FIFO frees the slot being written in the same cycle.
  assign w_push  = i_push && (!w_full || i_pop);
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/l1_map_streamer.sv
// Reads the 32x32 max-pooled map from L1_MEM in raster order, streams every word
// on a valid/ready port with back-pressure, and reports the rounded global average.
// Ports:
//  clk, reset           posedge clock, synchronous active-high reset
//  start                1-cycle pulse starting a pass (ignored while busy)
//  busy, done           pass in progress / 1-cycle completion pulse
//  crd, caddr_rd, csel  memory read port (owned only while busy)
//  cdata_rd             read data, one cycle after crd
//  m_valid/m_data/m_last/m_ready   output stream
//  avg_data             (sum + 512) >> 10, held until the next start
module l1_map_streamer
  import conv_pkg::*;
#(
  parameter int         MAP_W      = 32,
  parameter int         MAP_H      = 32,
  parameter int         DATA_W     = 20,
  parameter int         ADDR_W     = 12,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] L1_SEL     = CSEL_L1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic [2:0]        csel,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [DATA_W-1:0] avg_data
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_W * MAP_H - 1);

  stream_state_e     r_state;
  stream_state_e     w_next_state;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_issue;
  logic              r_crd;
  logic [ADDR_W-1:0] r_caddr;
  logic              r_rd_last;    // the read on the bus this cycle is the last address
  logic              r_resp;       // cdata_rd carries a word this cycle
  logic              r_resp_last;
  logic              r_busy;
  logic [2:0]        r_csel;
  logic              r_done;
  logic [DATA_W-1:0] r_avg;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic [CNT_W:0]    w_outstanding;
  logic              w_credit_ok;
  logic [DATA_W:0]   w_head;

  // Every word already requested but not yet popped occupies a FIFO slot:
  // those in the FIFO, the one returning now and the one requested now.
  assign w_outstanding = {1'b0, w_fifo_count} + (CNT_W+1)'(r_crd) + (CNT_W+1)'(r_resp);
  assign w_credit_ok   = (w_outstanding < (CNT_W+1)'(FIFO_DEPTH));

  // Next-state and read-issue decision.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_next_addr;
    case (r_state)
      IDLE: begin
        if (start) begin
          // First read goes out together with start acceptance to save a cycle.
          w_issue      = 1'b1;
          w_issue_addr = '0;
          w_next_state = READ;
        end else begin
          w_next_state = IDLE;
        end
      end
      READ: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (r_next_addr == LAST_ADDR) begin
            w_next_state = DRAIN;
          end else begin
            w_next_state = READ;
          end
        end else begin
          w_next_state = READ;
        end
      end
      DRAIN: begin
        if (w_fifo_empty && !r_crd && !r_resp) begin
          w_next_state = FIN;
        end else begin
          w_next_state = DRAIN;
        end
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Read port, response pipeline, status flags and accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crd       <= 1'b0;
      r_caddr     <= '0;
      r_next_addr <= '0;
      r_rd_last   <= 1'b0;
      r_resp      <= 1'b0;
      r_resp_last <= 1'b0;
      r_busy      <= 1'b0;
      r_csel      <= CSEL_NONE;
      r_done      <= 1'b0;
      r_avg       <= '0;
      r_sum       <= '0;
    end else begin
      r_crd       <= w_issue;
      r_rd_last   <= w_issue && (w_issue_addr == LAST_ADDR);
      r_resp      <= r_crd;
      r_resp_last <= r_rd_last;
      if (w_issue) begin
        r_caddr     <= w_issue_addr;
        r_next_addr <= w_issue_addr + ADDR_W'(1);
      end
      if (r_state == IDLE && start) begin
        r_busy <= 1'b1;
        r_csel <= L1_SEL;
        r_sum  <= '0;
      end else begin
        if (r_state == FIN) begin
          r_busy <= 1'b0;
          r_csel <= CSEL_NONE;
        end
        if (r_resp) begin
          r_sum <= r_sum + SUM_W'(cdata_rd);
        end
      end
      // Nothing is in flight on the DRAIN->FIN edge, so the sum is final here.
      r_done <= (r_state == DRAIN) && (w_next_state == FIN);
      if ((r_state == DRAIN) && (w_next_state == FIN)) begin
        r_avg <= DATA_W'(round_avg(r_sum));
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_resp),
    .i_data  ({r_resp_last, cdata_rd}),
    .i_pop   (m_valid && m_ready),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd;
  assign caddr_rd = r_caddr;
  assign csel     = r_csel;
  assign avg_data = r_avg;
  assign m_valid  = !w_fifo_empty;
  assign m_data   = w_head[DATA_W-1:0];
  assign m_last   = w_head[DATA_W];

endmodule

// File: tb/tb_l1_map_streamer.sv
// Directed bench for l1_map_streamer: a behavioural L1_MEM (1-cycle read latency),
// a stream/read-port monitor and a sequence of directed runs with hand-computed averages.
module tb_l1_map_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic        m_valid;
  logic [19:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic [19:0] avg_data;

  int n_vec  = 0;
  int n_miss = 0;

  logic [19:0] tb_mem [1024];

  int          rd_seen;
  int          pop_seen;
  int          exp_addr;
  int          done_cnt;
  logic        hold_v;
  logic [20:0] hold_word;

  always #5 clk = ~clk;

  l1_map_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .avg_data (avg_data)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // L1_MEM model: data appears the cycle after crd.
  always @(posedge clk) begin
    if (crd) cdata_rd <= tb_mem[caddr_rd[9:0]];
  end

  // Monitor: address contiguity, credit bound, stream order/last, hold stability, done count.
  always @(negedge clk) begin
    if (reset) begin
      rd_seen  = 0;
      pop_seen = 0;
      exp_addr = 0;
      done_cnt = 0;
      hold_v   = 1'b0;
    end else begin
      if (crd) begin
        check_vec("rd_addr", {20'd0, caddr_rd}, exp_addr);
        exp_addr++;
        rd_seen++;
      end
      if (busy) check_vec("credit", {31'd0, (rd_seen - pop_seen) <= 4}, 32'd1);
      if (hold_v) begin
        check_vec("hold_valid", {31'd0, m_valid}, 32'd1);
        check_vec("hold_word", {11'd0, m_last, m_data}, {11'd0, hold_word});
      end
      if (m_valid && m_ready) begin
        if (pop_seen < 1024) begin
          check_vec("data", {12'd0, m_data}, {12'd0, tb_mem[pop_seen]});
          check_vec("last", {31'd0, m_last}, {31'd0, pop_seen == 1023});
        end else begin
          check_vec("overrun", pop_seen, 32'd1023);
        end
        pop_seen++;
      end
      hold_v    = m_valid && !m_ready;
      hold_word = {m_last, m_data};
      if (done) done_cnt++;
    end
  end

  task automatic fill(input int kind);
    for (int i = 0; i < 1024; i++) begin
      case (kind)
        0:       tb_mem[i] = 20'(i);
        1:       tb_mem[i] = 20'hFFFFF;
        2:       tb_mem[i] = 20'h00001;
        default: tb_mem[i] = (i < 512) ? 20'h00001 : 20'h00000;
      endcase
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return (cyc >= 50);
    endcase
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_map(input string tag, input int mode, input logic [19:0] exp_avg,
                         input bit mid_start, input bit chk_lat, input bit do_rst);
    int cyc;
    if (do_rst) pulse_reset();
    m_ready = (mode == 2) ? 1'b0 : 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_vec({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    check_vec({tag, "_crd1"}, {31'd0, crd}, 32'd1);
    check_vec({tag, "_addr0"}, {20'd0, caddr_rd}, 32'd0);
    check_vec({tag, "_csel"}, {29'd0, csel}, 32'd3);
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      if (chk_lat && cyc == 1) check_vec({tag, "_lat_v0"}, {31'd0, m_valid}, 32'd0);
      if (chk_lat && cyc == 2) begin
        check_vec({tag, "_lat_v1"}, {31'd0, m_valid}, 32'd1);
        check_vec({tag, "_lat_d"}, {12'd0, m_data}, 32'd0);
      end
      if (mode == 2 && cyc == 50) begin
        check_vec({tag, "_stall_rds"}, rd_seen, 32'd4);
        check_vec({tag, "_stall_crd"}, {31'd0, crd}, 32'd0);
        check_vec({tag, "_stall_busy"}, {31'd0, busy}, 32'd1);
        check_vec({tag, "_stall_done"}, done_cnt, 32'd0);
      end
      m_ready = ready_for(mode, cyc);
      start   = mid_start && (cyc == 100);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check_vec({tag, "_timeout"}, {31'd0, cyc < 20000}, 32'd1);
    check_vec({tag, "_words"}, pop_seen, 32'd1024);
    check_vec({tag, "_reads"}, rd_seen, 32'd1024);
    check_vec({tag, "_avg"}, {12'd0, avg_data}, {12'd0, exp_avg});
    check_vec({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check_vec({tag, "_csel_off"}, {29'd0, csel}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_vec({tag, "_done_once"}, done_cnt, 32'd1);
    check_vec({tag, "_avg_hold"}, {12'd0, avg_data}, {12'd0, exp_avg});
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_busy", {31'd0, busy}, 32'd0);
    check_vec("rst_done", {31'd0, done}, 32'd0);
    check_vec("rst_crd", {31'd0, crd}, 32'd0);
    check_vec("rst_addr", {20'd0, caddr_rd}, 32'd0);
    check_vec("rst_csel", {29'd0, csel}, 32'd0);
    check_vec("rst_valid", {31'd0, m_valid}, 32'd0);
    check_vec("rst_avg", {12'd0, avg_data}, 32'd0);
    reset = 1'b0;

    // Ramp map: sum 523776, (523776+512)>>10 = 512.
    fill(0);
    run_map("t1", 0, 20'h00200, 1'b0, 1'b1, 1'b1);
    run_map("t2", 1, 20'h00200, 1'b0, 1'b0, 1'b1);
    // 1024*0xFFFFF = 0x3FFFFC00; +0x200, >>10 -> 0xFFFFF.
    fill(1);
    run_map("t3a", 0, 20'hFFFFF, 1'b0, 1'b0, 1'b1);
    // 1024 ones: (1024+512)>>10 = 1.
    fill(2);
    run_map("t3b", 0, 20'h00001, 1'b0, 1'b0, 1'b1);
    // 512 ones: (512+512)>>10 = 1 (exact half rounds up).
    fill(3);
    run_map("t3c", 0, 20'h00001, 1'b0, 1'b0, 1'b1);
    fill(0);
    run_map("t4", 1, 20'h00200, 1'b1, 1'b0, 1'b1);

    // Abort with two words parked in the FIFO.
    pulse_reset();
    m_ready = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_vec("t5_pre_valid", {31'd0, m_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_vec("t5_valid", {31'd0, m_valid}, 32'd0);
    check_vec("t5_busy", {31'd0, busy}, 32'd0);
    check_vec("t5_crd", {31'd0, crd}, 32'd0);
    check_vec("t5_csel", {29'd0, csel}, 32'd0);
    check_vec("t5_done", {31'd0, done}, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check_vec("t5_no_done", {31'd0, done}, 32'd0);
    end
    run_map("t5", 0, 20'h00200, 1'b0, 1'b1, 1'b0);

    run_map("t6", 2, 20'h00200, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
